// File: rtl/sv_uart_word_packer.sv
// ============================================================================
// Module   : sv_uart_word_packer
// Packs consecutive UART receive bytes (first byte in MSBs) into one
// DATA_WIDTH word; a partial word is dropped after an inter-byte timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sv_uart_word_packer #(
  parameter int DATA_WIDTH    = 24,
  parameter int TIMEOUT_BYTES = 2
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [15:0]           idivider,
  output logic                  odrop
);

  localparam int C_WORDS_NUM = DATA_WIDTH / 8;
  localparam int C_CNT_W     = $clog2(C_WORDS_NUM);
  localparam int C_MULT      = TIMEOUT_BYTES * 10;
  localparam int C_MULT_W    = (C_MULT > 1) ? $clog2(C_MULT + 1) : 1;
  localparam int C_TMR_W     = (16 + C_MULT_W > 24) ? (16 + C_MULT_W) : 24;
  localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(C_WORDS_NUM - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [C_CNT_W-1:0]    r_byte_cnt;
  logic [C_CNT_W-1:0]    w_byte_cnt_nxt;
  logic [C_TMR_W-1:0]    r_timer;
  logic [C_TMR_W-1:0]    w_timer_nxt;
  logic [C_TMR_W-1:0]    w_thresh;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  r_m_valid;
  logic                  r_drop;
  logic                  w_drop_nxt;
  logic                  w_to_en;
  logic                  w_accept;
  logic                  w_last;

  // Backpressure only when the final byte would need a busy output register.
  assign s_axis_tready = ~(r_m_valid && (r_byte_cnt == C_LAST_CNT));
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_last        = w_accept && (r_byte_cnt == C_LAST_CNT);
  assign w_word        = {r_shift[DATA_WIDTH-9:0], s_axis_tdata};
  assign w_thresh      = C_TMR_W'(idivider) * C_TMR_W'(C_MULT);
  assign w_to_en       = (TIMEOUT_BYTES != 0) && (idivider != 16'd0);

  assign m_axis_tdata  = r_m_data;
  assign m_axis_tvalid = r_m_valid;
  assign odrop         = r_drop;

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
      r_timer    <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_timer    <= w_timer_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_timer_nxt    = r_timer;
    w_drop_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (w_accept) begin
          w_byte_cnt_nxt = C_CNT_W'(1);
          w_state_nxt    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_accept) begin
          w_timer_nxt = '0;
          if (r_byte_cnt == C_LAST_CNT) begin
            w_byte_cnt_nxt = '0;
            w_state_nxt    = ST_IDLE;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + C_CNT_W'(1);
          end
        end else if (w_to_en && (r_timer == w_thresh)) begin
          w_byte_cnt_nxt = '0;
          w_timer_nxt    = '0;
          w_state_nxt    = ST_IDLE;
          w_drop_nxt     = 1'b1;
        end else if (s_axis_tready && (r_timer != '1)) begin
          // A stall is backpressure, not a line gap, so the timer freezes.
          w_timer_nxt = r_timer + C_TMR_W'(1);
        end
      end
      default: begin
        w_byte_cnt_nxt = '0;
        w_timer_nxt    = '0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  // A dropped partial word is not cleared here; the next full word overwrites it.
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_shift   <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= w_word;
      end
      if (w_last) begin
        r_m_data  <= w_word;
        r_m_valid <= 1'b1;
      end else if (r_m_valid && m_axis_tready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sv_uart_word_packer.sv
// ============================================================================
// Module   : tb_sv_uart_word_packer
// Scoreboard bench for sv_uart_word_packer with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sv_uart_word_packer;

  localparam int DW = 24;
  localparam int NW = DW / 8;

  logic          iclk = 1'b0;
  logic          irst = 1'b1;
  logic [7:0]    s_tdata = 8'h00;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_ready = 1'b1;
  logic          m_ready_c = 1'b1;
  logic          mr_rand = 1'b0;
  logic [15:0]   idiv = 16'd4;
  logic          odrop;

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;
  int n_drops  = 0;
  bit model_on = 1'b0;

  logic [7:0]    part[$];
  logic [DW-1:0] sb[$];
  bit            mo_valid = 1'b0;
  bit            exp_drop = 1'b0;
  int            elapsed  = 0;

  sv_uart_word_packer #(.DATA_WIDTH(DW), .TIMEOUT_BYTES(2)) dut (
    .iclk          (iclk),
    .irst          (irst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_ready),
    .idivider      (idiv),
    .odrop         (odrop)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) begin
    #1;
    m_ready = mr_rand ? 1'($urandom_range(0, 1)) : m_ready_c;
  end

  task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: one step per cycle, using the byte queue of the open word.
  always @(negedge iclk) begin : model
    bit            et;
    bit            acc;
    bit            drp;
    int            thr;
    logic [DW-1:0] w;
    if (model_on) begin
      et = !(mo_valid && part.size() == NW - 1);
      check("s_tready", DW'(s_tready), DW'(et));
      check("m_tvalid", DW'(m_tvalid), DW'(mo_valid));
      check("odrop", DW'(odrop), DW'(exp_drop));
      if (irst) begin
        part.delete();
        sb.delete();
        mo_valid = 1'b0;
        exp_drop = 1'b0;
        elapsed  = 0;
      end else begin
        thr = 20 * int'(idiv);
        acc = s_tvalid && et;
        drp = (part.size() > 0) && !acc && (idiv != 16'd0) && (elapsed == thr);
        if (mo_valid && m_ready) mo_valid = 1'b0;
        exp_drop = drp;
        if (acc) begin
          part.push_back(s_tdata);
          elapsed = 0;
          if (part.size() == NW) begin
            w = '0;
            foreach (part[k]) w = (w << 8) | DW'(part[k]);
            sb.push_back(w);
            mo_valid = 1'b1;
            part.delete();
          end
        end else if (drp) begin
          part.delete();
          elapsed = 0;
        end else if (part.size() > 0 && et) begin
          elapsed++;
        end
      end
    end
  end

  always @(negedge iclk) begin
    if (model_on && !irst && m_tvalid && m_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL word: got %h expected none at %0t", m_tdata, $time);
      end else begin
        check("word", m_tdata, sb.pop_front());
      end
      n_words++;
    end
    if (model_on && odrop) n_drops++;
  end

  task automatic put_byte(input logic [7:0] b);
    bit got;
    int t;
    t = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    do begin
      @(negedge iclk);
      got = s_tready;
      @(posedge iclk);
      #1;
      t++;
    end while (!got && t < 2000);
    s_tvalid = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL put_byte: byte %h not accepted within %0d cycles", b, t);
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    irst = 1'b1;
    @(posedge iclk);
    #1;
    irst = 1'b0;
  endtask

  initial begin
    int d0;
    int w0;
    repeat (2) @(posedge iclk);
    #1;
    model_on = 1'b1;
    check("rst_tdata", m_tdata, '0);
    check("rst_tvalid", DW'(m_tvalid), '0);
    check("rst_odrop", DW'(odrop), '0);
    check("rst_tready", DW'(s_tready), DW'(1));
    @(posedge iclk);
    #1;
    irst = 1'b0;

    // Basic word and its one-cycle latency.
    put_byte(8'h12);
    put_byte(8'h34);
    put_byte(8'h56);
    check("basic_lat_valid", DW'(m_tvalid), DW'(1));
    check("basic_lat_data", m_tdata, 24'h123456);
    idle(3);

    // Backpressure: sixth byte must stall until the held word is taken.
    m_ready_c = 1'b0;
    idle(2);
    w0 = n_words;
    fork
      begin
        for (int i = 0; i < 6; i++) put_byte(8'hA1 + 8'(i));
      end
      begin
        repeat (20) @(posedge iclk);
        #2;
        check("bp_tready", DW'(s_tready), '0);
        check("bp_hold", m_tdata, 24'hA1A2A3);
        m_ready_c = 1'b1;
      end
    join
    idle(5);
    check("bp_words", DW'(n_words - w0), DW'(2));

    // Back-to-back bytes.
    w0 = n_words;
    for (int i = 0; i < 9; i++) put_byte(8'(8'h30 + i));
    idle(4);
    check("b2b_words", DW'(n_words - w0), DW'(3));

    // Timeout drop, exact-threshold accept, one-past-threshold drop.
    d0 = n_drops;
    put_byte(8'h11);
    idle(100);
    put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
    idle(3);
    check("to_drop_once", DW'(n_drops - d0), DW'(1));
    d0 = n_drops;
    put_byte(8'h55); idle(80); put_byte(8'h66); idle(80); put_byte(8'h77);
    idle(3);
    check("to_exact_nodrop", DW'(n_drops - d0), '0);
    d0 = n_drops;
    put_byte(8'h88); idle(81); put_byte(8'h99); put_byte(8'h9A); put_byte(8'h9B);
    idle(3);
    check("to_past_drop", DW'(n_drops - d0), DW'(1));

    // Reset mid-word.
    d0 = n_drops;
    put_byte(8'h01); put_byte(8'h02);
    pulse_reset();
    put_byte(8'hAA); put_byte(8'hBB); put_byte(8'hCC);
    idle(3);
    check("rst_mid_nodrop", DW'(n_drops - d0), '0);

    // Timeout disabled.
    idiv = 16'd0;
    d0 = n_drops;
    put_byte(8'hC1); idle(1000); put_byte(8'hC2); idle(1000); put_byte(8'hC3);
    idle(3);
    check("dis_nodrop", DW'(n_drops - d0), '0);

    // Randomized traffic with random downstream readiness.
    mr_rand = 1'b1;
    for (int r = 0; r < 4; r++) begin
      idiv = 16'($urandom_range(0, 3));
      pulse_reset();
      for (int i = 0; i < 80; i++) begin
        put_byte(8'($urandom));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 70));
        else idle($urandom_range(0, 2));
      end
    end
    mr_rand = 1'b0;
    m_ready_c = 1'b1;
    idle(10);
    check("sb_empty", DW'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
